// File: rtl/pll_reconfig_pkg.sv
// Shared types and register map for the PLL reconfiguration sequencer.
package pll_reconfig_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_MIF_ADDR = 6'd31;
  localparam logic [ADDR_W-1:0] REG_START    = 6'd2;

  typedef enum logic [2:0] {
    StIdle,
    StWrMif,
    StGap,
    StWrStart,
    StSettle,
    StWaitLock,
    StError
  } state_e;

  function automatic logic [DATA_W-1:0] mif_data(input logic [DATA_W-1:0] sel,
                                                 input int unsigned shift,
                                                 input int unsigned base);
    return (sel << shift) + DATA_W'(base);
  endfunction

endpackage

// File: rtl/sel_sync_filter.sv
// Two-flop synchroniser for a multi-bit select, followed by a stability filter that only
// accepts a value once it has been unchanged for STABLE_CYC cycles.
module sel_sync_filter #(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned STABLE_CYC = 16
) (
  input  logic             CLK_50M,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel_async,
  output logic [SEL_W-1:0] sel_filt,
  output logic             sel_valid,
  output logic             sel_chg
);

  localparam int unsigned CntW = $clog2(STABLE_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYC - 1);

  logic [SEL_W-1:0] meta_q, sync_q, hold_q, filt_q;
  logic [CntW-1:0]  cnt_q;
  logic             valid_q, chg_q;
  logic             stable;

  assign stable = (sync_q == hold_q) && (cnt_q == CntLast);

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      meta_q  <= '0;
      sync_q  <= '0;
      hold_q  <= '0;
      filt_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      meta_q <= sel_async;
      sync_q <= meta_q;
      chg_q  <= 1'b0;
      if (sync_q != hold_q) begin
        hold_q <= sync_q;
        cnt_q  <= '0;
      end else if (cnt_q != CntLast) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (stable) begin
        filt_q  <= hold_q;
        valid_q <= 1'b1;
        // The first acceptance after reset is not a change; the reset request covers it.
        chg_q   <= valid_q && (filt_q != hold_q);
      end
    end
  end

  assign sel_filt  = filt_q;
  assign sel_valid = valid_q;
  assign sel_chg   = chg_q;

endmodule

// File: rtl/pll_reconfig_seq.sv
// Sequencer that programs a PLL reconfiguration controller over Avalon-MM: selects a MIF
// profile, starts the reconfig, then waits for lock with timeout and bounded retry.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned MIF_SHIFT    = 6,
  parameter int unsigned MIF_BASE     = 0,
  parameter int unsigned STABLE_CYC   = 16,
  parameter int unsigned SETTLE_CYC   = 8,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic              CLK_50M,
  input  logic              reset,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              force_i,
  output logic              mgmt_write,
  output logic [ADDR_W-1:0] mgmt_address,
  output logic [DATA_W-1:0] mgmt_writedata,
  input  logic              mgmt_waitrequest,
  input  logic              pll_locked,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [SEL_W-1:0]  cur_sel
);

  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

  logic [SEL_W-1:0] filt_sel;
  logic             filt_valid, sel_chg;

  sel_sync_filter #(
    .SEL_W      (SEL_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_sel_filter (
    .CLK_50M   (CLK_50M),
    .reset     (reset),
    .sel_async (sel_i),
    .sel_filt  (filt_sel),
    .sel_valid (filt_valid),
    .sel_chg   (sel_chg)
  );

  state_e            state_q, state_d;
  logic              pend_q, pend_d, pend_set, launch, accept, timeout;
  logic              lock_meta_q, lock_q;
  logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              write_q, write_d, done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign pend_set = force_i | (sel_chg & (filt_sel != cur_sel_q));
  // Launch waits for the first filtered select so the post-reset run uses a settled value.
  assign launch   = (pend_q | pend_set) & filt_valid & (state_q inside {StIdle, StError});
  assign pend_d   = launch ? 1'b0 : (pend_q | pend_set);
  assign accept   = write_q & ~mgmt_waitrequest;
  assign timeout  = (cnt_q == 32'(LOCK_TIMEOUT - 1));

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      state_q     <= StIdle;
      pend_q      <= 1'b1;
      cur_sel_q   <= '0;
      retry_q     <= '0;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cur_sel_q   <= cur_sel_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      lock_meta_q <= pll_locked;
      lock_q      <= lock_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    cur_sel_d = cur_sel_q;
    unique case (state_q)
      StIdle, StError: begin
        if (launch) begin
          state_d   = StWrMif;
          cur_sel_d = filt_sel;
          retry_d   = '0;
        end
      end
      StWrMif:   if (accept) state_d = StGap;
      StGap:     state_d = StWrStart;
      StWrStart: begin
        if (accept) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (cnt_q + 32'd1 >= 32'(SETTLE_CYC)) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StWaitLock: begin
        if (lock_q) begin
          state_d = StIdle;
        end else if (timeout) begin
          if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + RetryW'(1);
            state_d = StWrMif;
          end else begin
            state_d = StError;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    write_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      StWrMif: begin
        write_d = ~accept;
        addr_d  = REG_MIF_ADDR;
        data_d  = mif_data(DATA_W'(cur_sel_q), MIF_SHIFT, MIF_BASE);
      end
      StWrStart: begin
        write_d = ~accept;
        addr_d  = REG_START;
        data_d  = '0;
      end
      StWaitLock: done_d = lock_q;
      default: ;
    endcase
  end

  assign mgmt_write     = write_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign done           = done_q;
  assign busy           = !(state_q inside {StIdle, StError});
  assign error          = (state_q == StError);
  assign cur_sel        = cur_sel_q;

endmodule
